// File: rtl/mul_master.sv
// mul_master: requester-side sequencer for the iterative multiplier core.
// Takes one operand pair from an upstream valid/ready port and runs one
// start / wait-for-done / clear sequence on the core. It then returns the
// captured 128-bit product on a downstream valid/ready port.
// Optional feature macro: MUL_MASTER_TIMEOUT_EN. When it is defined, a
// 16-bit WAIT counter abandons the operation after TIMEOUT cycles and flags
// rsp_error. When it is undefined, WAIT exits only on op_done and rsp_error
// is tied low.
module mul_master #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [63:0]  req_a,
  input  logic [63:0]  req_b,
  output logic [63:0]  multiplicand,
  output logic [63:0]  multiplier,
  output logic         op_start,
  output logic         op_clear,
  input  logic         op_done,
  input  logic [127:0] result,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_result,
  output logic         rsp_error
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CLEAR = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Reject an out-of-range TIMEOUT at elaboration rather than wrapping the counter.
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("mul_master: TIMEOUT must be in 1..65535");
  end

  state_e       state_q, state_d;
  logic [63:0]  mcand_q, mcand_d;
  logic [63:0]  mplier_q, mplier_d;
  logic [127:0] result_q, result_d;

`ifdef MUL_MASTER_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  logic [15:0]  cnt_q, cnt_d;
  logic         error_q, error_d;
`endif

  // Next-state and datapath update for the request/operation/response sequence.
  always_comb begin
    // NOTE: every variable written here is given its hold value first, so no path can infer a latch.
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
`ifdef MUL_MASTER_TIMEOUT_EN
    cnt_d    = cnt_q;
    error_d  = error_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // req_ready is high for the whole of IDLE, so req_valid alone completes the handshake.
        if (req_valid) begin
          mcand_d  = req_a;
          mplier_d = req_b;
`ifdef MUL_MASTER_TIMEOUT_EN
          error_d  = 1'b0;
`endif
          state_d  = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
`ifdef MUL_MASTER_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_WAIT: begin
        // op_done takes priority over counter expiry on the same edge.
        if (op_done) begin
          result_d = result;
          state_d  = ST_CLEAR;
        end
`ifdef MUL_MASTER_TIMEOUT_EN
        else if (cnt_q == WAIT_LAST) begin
          error_d  = 1'b1;
          result_d = '0;
          state_d  = ST_CLEAR;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      ST_CLEAR: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      // NOTE: unused encodings (5..7) recover to IDLE instead of locking up the sequencer.
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
`ifdef MUL_MASTER_TIMEOUT_EN
      cnt_q    <= '0;
      error_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from the same pre-edge values.
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
`ifdef MUL_MASTER_TIMEOUT_EN
      cnt_q    <= cnt_d;
      error_q  <= error_d;
`endif
    end
  end

  // Moore outputs decoded from the registered state; no input reaches an output combinationally.
  assign req_ready    = (state_q == ST_IDLE);
  assign op_start     = (state_q == ST_START);
  assign op_clear     = (state_q == ST_CLEAR);
  assign rsp_valid    = (state_q == ST_RESP);
  assign multiplicand = mcand_q;
  assign multiplier   = mplier_q;
  assign rsp_result   = result_q;
`ifdef MUL_MASTER_TIMEOUT_EN
  assign rsp_error    = error_q;
`else
  assign rsp_error    = 1'b0;
`endif

endmodule

// File: tb/tb_mul_master.sv
// tb_mul_master: self-checking bench for mul_master.
// A behavioural multiplier core with programmable latency answers the
// start/clear handshake. Each transaction is checked against the arithmetic
// product and against the cycle positions the sequencer is expected to hold.
// Timeout scenarios are only exercised when MUL_MASTER_TIMEOUT_EN is defined.
module tb_mul_master;

  localparam int TIMEOUT = 64;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req_valid;
  logic         req_ready;
  logic [63:0]  req_a, req_b;
  logic [63:0]  multiplicand, multiplier;
  logic         op_start, op_clear, op_done;
  logic [127:0] result;
  logic         rsp_valid, rsp_ready;
  logic [127:0] rsp_result;
  logic         rsp_error;

  int n_checks = 0;
  int n_fail   = 0;
  int lat_cfg  = 1;     // core latency in cycles after op_start; 0 means never done
  int excl_viol  = 0;
  int order_viol = 0;

  mul_master #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .op_start     (op_start),
    .op_clear     (op_clear),
    .op_done      (op_done),
    .result       (result),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_error    (rsp_error)
  );

  always #5 clk = ~clk;

  // Behavioural core: op_done rises lat_cfg cycles after the op_start cycle and holds until op_clear.
  logic [63:0] core_a, core_b;
  logic        core_busy;
  int          core_cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_busy <= 1'b0;
      core_cnt  <= 0;
      op_done   <= 1'b0;
      result    <= '0;
      core_a    <= '0;
      core_b    <= '0;
    end else if (op_clear) begin
      core_busy <= 1'b0;
      op_done   <= 1'b0;
    end else if (op_start) begin
      core_busy <= 1'b1;
      core_cnt  <= 1;
      core_a    <= multiplicand;
      core_b    <= multiplier;
      if (lat_cfg == 1) begin
        op_done <= 1'b1;
        result  <= 128'(multiplicand) * 128'(multiplier);
      end
    end else if (core_busy && !op_done) begin
      core_cnt <= core_cnt + 1;
      if (lat_cfg != 0 && core_cnt + 1 == lat_cfg) begin
        op_done <= 1'b1;
        result  <= 128'(core_a) * 128'(core_b);
      end
    end
  end

  // Protocol monitor: start/clear exclusivity and start only after the previous clear.
  bit outstanding = 1'b0;
  always @(negedge clk) begin
    if (reset_n !== 1'b1) begin
      outstanding = 1'b0;
    end else begin
      if (op_start && op_clear) excl_viol++;
      if (op_start) begin
        if (outstanding) order_viol++;
        outstanding = 1'b1;
      end
      if (op_clear) outstanding = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction; call and return at a falling edge. Cycle 0 is the acceptance cycle.
  // lat == 0 models a core that never finishes (timeout expected).
  task automatic run_txn(input string name, input logic [63:0] a, input logic [63:0] b,
                         input int lat, input int stall, input bit pend,
                         input logic [63:0] pa, input logic [63:0] pb);
    logic [127:0] exp_res;
    bit           exp_err;
    int c_start = -1, n_start = 0, c_done = -1, c_clear = -1, n_clear = 0, c_rsp = -1;
    int waited = 0;
    exp_err = (lat == 0);
    exp_res = exp_err ? 128'd0 : 128'(a) * 128'(b);
    lat_cfg = lat;
    while (req_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check({name, ":req_ready"}, 128'(req_ready), 128'd1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 200 && c_rsp < 0; c++) begin
      @(negedge clk);
      if (op_start) begin
        n_start++;
        if (c_start < 0) c_start = c;
      end
      if (op_done && c_done < 0) c_done = c;
      if (op_clear) begin
        n_clear++;
        if (c_clear < 0) c_clear = c;
      end
      if (rsp_valid && c_rsp < 0) c_rsp = c;
      if (c == 1) begin
        check({name, ":multiplicand"}, 128'(multiplicand), 128'(a));
        check({name, ":multiplier"}, 128'(multiplier), 128'(b));
      end
    end
    check({name, ":start_cycle"}, 128'(c_start), 128'(1));
    check({name, ":start_count"}, 128'(n_start), 128'(1));
    check({name, ":clear_count"}, 128'(n_clear), 128'(1));
    if (exp_err) begin
      check({name, ":clear_cycle"}, 128'(c_clear), 128'(TIMEOUT + 2));
    end else begin
      check({name, ":done_cycle"}, 128'(c_done), 128'(lat + 1));
      check({name, ":clear_after_done"}, 128'(c_clear), 128'(c_done + 1));
    end
    check({name, ":rsp_cycle"}, 128'(c_rsp), 128'(c_clear + 1));
    check({name, ":rsp_result"}, rsp_result, exp_res);
    check({name, ":rsp_error"}, 128'(rsp_error), 128'(exp_err));
    for (int s = 0; s < stall; s++) begin
      if (pend) begin
        req_valid = 1'b1;
        req_a     = pa;
        req_b     = pb;
      end
      @(negedge clk);
      check({name, ":stall_valid"}, 128'(rsp_valid), 128'd1);
      check({name, ":stall_result"}, rsp_result, exp_res);
      check({name, ":stall_error"}, 128'(rsp_error), 128'(exp_err));
      check({name, ":stall_req_ready"}, 128'(req_ready), 128'd0);
      if (pend) check({name, ":stall_operand"}, 128'(multiplicand), 128'(a));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check({name, ":rsp_dropped"}, 128'(rsp_valid), 128'd0);
    check({name, ":back_to_idle"}, 128'(req_ready), 128'd1);
    if (pend) check({name, ":pend_not_started"}, 128'(op_start), 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int n_clear_after, n_rsp_after;
    logic [63:0] ra, rb;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst:req_ready", 128'(req_ready), 128'd1);
    check("rst:op_start", 128'(op_start), 128'd0);
    check("rst:op_clear", 128'(op_clear), 128'd0);
    check("rst:rsp_valid", 128'(rsp_valid), 128'd0);
    check("rst:rsp_error", 128'(rsp_error), 128'd0);
    check("rst:rsp_result", rsp_result, 128'd0);
    check("rst:multiplicand", 128'(multiplicand), 128'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic product, max operands, done/timeout collision (done first seen with counter at 63).
    run_txn("basic", 64'd3, 64'd5, 32, 0, 1'b0, '0, '0);
    run_txn("max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5, 0, 1'b0, '0, '0);
    check("max:product", rsp_result, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    run_txn("collide", 64'd1234567, 64'd7654321, TIMEOUT, 0, 1'b0, '0, '0);
    run_txn("lat1", 64'd11, 64'd13, 1, 0, 1'b0, '0, '0);

`ifdef MUL_MASTER_TIMEOUT_EN
    run_txn("timeout", 64'd21, 64'd2, 0, 2, 1'b0, '0, '0);
    run_txn("after_timeout", 64'd6, 64'd7, 4, 0, 1'b0, '0, '0);
`endif

    // Backpressure: rsp_ready low for 10 cycles with a new request pending upstream.
    ra = {$urandom, $urandom};
    rb = {$urandom, $urandom};
    run_txn("bp", 64'hDEAD_BEEF_0000_0001, 64'h10, 8, 10, 1'b1, ra, rb);
    run_txn("bp_next", ra, rb, 3, 0, 1'b0, '0, '0);

    // Randomized operands, latencies and response stalls.
    for (int i = 0; i < 12; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      run_txn("rand", ra, rb, int'($urandom_range(1, 40)), int'($urandom_range(0, 3)), 1'b0, '0, '0);
    end

    // Reset during WAIT with a core that would never finish.
    lat_cfg   = 0;
    req_valid = 1'b1;
    req_a     = 64'd100;
    req_b     = 64'd200;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst:req_ready", 128'(req_ready), 128'd1);
    check("midrst:op_start", 128'(op_start), 128'd0);
    check("midrst:op_clear", 128'(op_clear), 128'd0);
    check("midrst:rsp_valid", 128'(rsp_valid), 128'd0);
    check("midrst:rsp_error", 128'(rsp_error), 128'd0);
    check("midrst:rsp_result", rsp_result, 128'd0);
    check("midrst:multiplicand", 128'(multiplicand), 128'd0);
    check("midrst:multiplier", 128'(multiplier), 128'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    n_clear_after = 0;
    n_rsp_after   = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (op_clear) n_clear_after++;
      if (rsp_valid) n_rsp_after++;
    end
    check("midrst:no_clear", 128'(n_clear_after), 128'd0);
    check("midrst:no_rsp", 128'(n_rsp_after), 128'd0);
    run_txn("post_rst", 64'd7, 64'd9, 6, 0, 1'b0, '0, '0);
    check("post_rst:63", rsp_result, 128'd63);

    check("protocol:start_clear_exclusive", 128'(excl_viol), 128'd0);
    check("protocol:start_after_clear", 128'(order_viol), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
